// File: rtl/platform_pkg.sv
// Shared types, colour codes and coil sequences for the platform dispatch stage.
// Colour decode maps the sensor's one-hot code to a rotation direction and 45-degree unit count.
package platform_pkg;

  localparam logic [5:0] COL_RED    = 6'b000001;
  localparam logic [5:0] COL_BROWN  = 6'b000010;
  localparam logic [5:0] COL_YELLOW = 6'b000100;
  localparam logic [5:0] COL_ORANGE = 6'b001000;
  localparam logic [5:0] COL_BLUE   = 6'b010000;
  localparam logic [5:0] COL_GREEN  = 6'b100000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MOVE  = 2'd1,
    ST_DWELL = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    DIR_CW  = 1'b0,
    DIR_CCW = 1'b1
  } dir_e;

  // Sequence index 0 sits in the top nibble.
  localparam logic [15:0] CW_SEQ  = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
  localparam logic [15:0] CCW_SEQ = {4'b0001, 4'b0010, 4'b0100, 4'b1000};

  typedef struct packed {
    logic       valid;
    dir_e       dir;
    logic [2:0] units;
  } col_decode_t;

  function automatic logic [3:0] phase_pattern(dir_e dir, logic [1:0] idx);
    logic [15:0] seq;
    logic [3:0]  pat;
    seq = (dir == DIR_CW) ? CW_SEQ : CCW_SEQ;
    case (idx)
      2'd0:    pat = seq[15:12];
      2'd1:    pat = seq[11:8];
      2'd2:    pat = seq[7:4];
      default: pat = seq[3:0];
    endcase
    return pat;
  endfunction

  function automatic col_decode_t decode_colour(logic [5:0] code);
    col_decode_t d;
    d = '{valid: 1'b0, dir: DIR_CW, units: 3'd0};
    case (code)
      COL_RED:    d = '{valid: 1'b1, dir: DIR_CW,  units: 3'd2};
      COL_BROWN:  d = '{valid: 1'b1, dir: DIR_CW,  units: 3'd3};
      COL_YELLOW: d = '{valid: 1'b1, dir: DIR_CW,  units: 3'd4};
      COL_ORANGE: d = '{valid: 1'b1, dir: DIR_CCW, units: 3'd3};
      COL_BLUE:   d = '{valid: 1'b1, dir: DIR_CCW, units: 3'd1};
      COL_GREEN:  d = '{valid: 1'b1, dir: DIR_CCW, units: 3'd2};
      default:    d = '{valid: 1'b0, dir: DIR_CW,  units: 3'd0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/stepper_phase_gen.sv
// Four-phase coil sequencer: holds each phase for PHASE_CYCLES, steps through a latched phase total.
// Direction and total are captured on the cycle enable rises; last strobes in the final move cycle.
module stepper_phase_gen
  import platform_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = 97_656
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic        hold_i,
  input  dir_e        dir_i,
  input  logic [31:0] total_i,
  output logic [3:0]  coil_o,
  output logic        last_o
);

  localparam logic [31:0] CYC_LOAD = 32'(PHASE_CYCLES - 1);

  logic        active_q, active_d;
  dir_e        dir_q, dir_d;
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] left_q, left_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  coil_q, coil_d;

  always_comb begin
    active_d = active_q;
    dir_d    = dir_q;
    cyc_d    = cyc_q;
    left_d   = left_q;
    idx_d    = idx_q;
    coil_d   = coil_q;
    if (!enable_i) begin
      active_d = 1'b0;
      cyc_d    = '0;
      left_d   = '0;
      idx_d    = '0;
      coil_d   = hold_i ? coil_q : 4'b0000;
    end else if (!active_q) begin
      active_d = 1'b1;
      dir_d    = dir_i;
      cyc_d    = CYC_LOAD;
      left_d   = total_i - 32'd1;
      idx_d    = 2'd0;
      coil_d   = phase_pattern(dir_i, 2'd0);
    end else if (cyc_q == '0) begin
      // Final phase just stays put until the controller drops enable.
      if (left_q != '0) begin
        cyc_d  = CYC_LOAD;
        left_d = left_q - 32'd1;
        idx_d  = idx_q + 2'd1;
        coil_d = phase_pattern(dir_q, idx_q + 2'd1);
      end
    end else begin
      cyc_d = cyc_q - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      dir_q    <= DIR_CW;
      cyc_q    <= '0;
      left_q   <= '0;
      idx_q    <= '0;
      coil_q   <= '0;
    end else begin
      active_q <= active_d;
      dir_q    <= dir_d;
      cyc_q    <= cyc_d;
      left_q   <= left_d;
      idx_q    <= idx_d;
      coil_q   <= coil_d;
    end
  end

  assign coil_o = coil_q;
  assign last_o = active_q && (cyc_q == '0) && (left_q == '0);

endmodule

// File: rtl/platform_dispatch.sv
// Outbound platform driver: feeder -> colour bin, dwell, then p3_on hand-off to the return stage.
// Build option PLATFORM_HOLD_EN keeps the last coil phase energised through the dwell.
//
// state    | meaning
// ST_IDLE  | coils off, waiting for start with a valid colour
// ST_MOVE  | stepping toward the bin
// ST_DWELL | parked at the bin while the M&M drops
// ST_DONE  | one-cycle p3_on hand-off, coils off
module platform_dispatch
  import platform_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = 97_656,
  parameter int unsigned STEPS_PER_45 = 32,
  parameter int unsigned DWELL_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] colour,
  output logic [3:0] GPIO_1,
  output logic       busy,
  output logic       p3_on,
  output logic       err
);

  localparam logic [31:0] DWELL_LOAD = (DWELL_CYCLES == 0) ? 32'd0 : 32'(DWELL_CYCLES - 1);
  localparam state_e      ST_AFTER_MOVE = (DWELL_CYCLES == 0) ? ST_DONE : ST_DWELL;

  state_e      state_q, state_d;
  logic [31:0] dwell_q, dwell_d;
  logic        busy_q, busy_d;
  logic        p3_q, p3_d;
  logic        err_q, err_d;

  col_decode_t dec;
  logic [31:0] total;
  logic        last;
  logic        gen_en;
  logic        gen_hold;

  assign dec   = decode_colour(colour);
  assign total = 32'(dec.units) * STEPS_PER_45;

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (dec.valid) state_d = (total == '0) ? ST_AFTER_MOVE : ST_MOVE;
          else           err_d   = 1'b1;
        end
      end
      ST_MOVE: begin
        if (last) state_d = ST_AFTER_MOVE;
      end
      ST_DWELL: begin
        if (dwell_q == '0) state_d = ST_DONE;
        else               dwell_d = dwell_q - 32'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_DWELL && state_q != ST_DWELL) dwell_d = DWELL_LOAD;
    busy_d = (state_d != ST_IDLE);
    p3_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dwell_q <= '0;
      busy_q  <= 1'b0;
      p3_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      busy_q  <= busy_d;
      p3_q    <= p3_d;
      err_q   <= err_d;
    end
  end

  // Driven from next state so the coil register lines up with busy.
  assign gen_en = (state_d == ST_MOVE);
`ifdef PLATFORM_HOLD_EN
  assign gen_hold = (state_d == ST_DWELL);
`else
  assign gen_hold = 1'b0;
`endif

  stepper_phase_gen #(
    .PHASE_CYCLES(PHASE_CYCLES)
  ) u_phase_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable_i(gen_en),
    .hold_i  (gen_hold),
    .dir_i   (dec.dir),
    .total_i (total),
    .coil_o  (GPIO_1),
    .last_o  (last)
  );

  assign busy  = busy_q;
  assign p3_on = p3_q;
  assign err   = err_q;

endmodule

// File: tb/tb_platform_dispatch.sv
// Bench for platform_dispatch with PHASE_CYCLES=4, STEPS_PER_45=2, DWELL_CYCLES=3.
// Expected traces come from a per-cycle model of the colour map and move timing.
module tb_platform_dispatch;

  localparam int PC = 4;
  localparam int SP = 2;
  localparam int DW = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] colour = 6'b0;
  logic [3:0] GPIO_1;
  logic       busy;
  logic       p3_on;
  logic       err;
  logic [6:0] obs;

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [5:0] valid_cols [6] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000};

  always #5 clk = ~clk;

  assign obs = {err, p3_on, busy, GPIO_1};

  platform_dispatch #(
    .PHASE_CYCLES(PC),
    .STEPS_PER_45(SP),
    .DWELL_CYCLES(DW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .colour(colour),
    .GPIO_1(GPIO_1),
    .busy  (busy),
    .p3_on (p3_on),
    .err   (err)
  );

  function automatic int units_of(logic [5:0] c);
    case (c)
      6'b000001: return 2;
      6'b000010: return 3;
      6'b000100: return 4;
      6'b001000: return 3;
      6'b010000: return 1;
      6'b100000: return 2;
      default:   return 0;
    endcase
  endfunction

  function automatic bit is_ccw(logic [5:0] c);
    return (c == 6'b001000) || (c == 6'b010000) || (c == 6'b100000);
  endfunction

  function automatic int move_len(logic [5:0] c);
    return units_of(c) * SP * PC;
  endfunction

  function automatic logic [3:0] pattern(logic [5:0] c, int ph);
    logic [3:0] one_cw;
    logic [3:0] one_ccw;
    one_cw  = 4'b1000;
    one_ccw = 4'b0001;
    return is_ccw(c) ? (one_ccw << (ph % 4)) : (one_cw >> (ph % 4));
  endfunction

  // {err, p3_on, busy, GPIO_1} in cycle cyc after the start edge (cycle 1 = first after the edge).
  function automatic logic [6:0] expect_at(logic [5:0] c, int cyc);
    int m;
    logic [3:0] pat;
    m = move_len(c);
    if (units_of(c) == 0) return (cyc == 1) ? 7'b100_0000 : 7'b000_0000;
    if (cyc >= 1 && cyc <= m) return {2'b00, 1'b1, pattern(c, (cyc - 1) / PC)};
    if (cyc <= m + DW) begin
`ifdef PLATFORM_HOLD_EN
      pat = pattern(c, (m - 1) / PC);
`else
      pat = 4'b0000;
`endif
      return {2'b00, 1'b1, pat};
    end
    if (cyc == m + DW + 1) return 7'b011_0000;
    return 7'b000_0000;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; colour = 6'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (obs !== 7'b0) begin
      bad_cnt++;
      $display("FAIL reset_hold got=%b want=%b", obs, 7'b0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (obs !== 7'b0) begin
      bad_cnt++;
      $display("FAIL reset_idle got=%b want=%b", obs, 7'b0);
    end
  endtask

  task automatic test_red();
    logic [5:0] c;
    c = 6'b000001;
    start = 1'b1; colour = c;
    @(posedge clk); #1;
    start = 1'b0; colour = 6'($urandom);
    for (int k = 1; k <= move_len(c) + DW + 2; k++) begin
      @(negedge clk);
      total_cnt++;
      if (obs !== expect_at(c, k)) begin
        bad_cnt++;
        $display("FAIL red cyc=%0d got=%b want=%b", k, obs, expect_at(c, k));
      end
    end
  endtask

  task automatic test_random_moves();
    logic [5:0] c;
    for (int n = 0; n < 8; n++) begin
      c = (n < 6) ? valid_cols[n] : valid_cols[$urandom_range(0, 5)];
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        total_cnt++;
        if (obs !== 7'b0) begin
          bad_cnt++;
          $display("FAIL gap_idle got=%b want=%b", obs, 7'b0);
        end
      end
      start = 1'b1; colour = c;
      @(posedge clk); #1;
      start = 1'b0; colour = 6'($urandom);
      for (int k = 1; k <= move_len(c) + DW + 2; k++) begin
        @(negedge clk);
        total_cnt++;
        if (obs !== expect_at(c, k)) begin
          bad_cnt++;
          $display("FAIL move col=%b cyc=%0d got=%b want=%b", c, k, obs, expect_at(c, k));
        end
      end
    end
  endtask

  task automatic test_invalid();
    logic [5:0] c;
    for (int n = 0; n < 5; n++) begin
      if (n == 0)      c = 6'b000011;
      else if (n == 1) c = 6'b000000;
      else begin
        c = 6'($urandom);
        while ($countones(c) == 1) c = 6'($urandom);
      end
      start = 1'b1; colour = c;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        total_cnt++;
        if (obs !== expect_at(c, k)) begin
          bad_cnt++;
          $display("FAIL invalid col=%b cyc=%0d got=%b want=%b", c, k, obs, expect_at(c, k));
        end
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [5:0] c;
    c = 6'b000001;
    start = 1'b1; colour = c;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= move_len(c) + DW + 2; k++) begin
      @(negedge clk);
      total_cnt++;
      if (obs !== expect_at(c, k)) begin
        bad_cnt++;
        $display("FAIL ignore_start cyc=%0d got=%b want=%b", k, obs, expect_at(c, k));
      end
      if (k == 6 || k == 20) begin
        start = 1'b1; colour = 6'b100000;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_midmove();
    logic [5:0] c;
    c = 6'b000100;
    start = 1'b1; colour = c;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      total_cnt++;
      if (obs !== expect_at(c, k)) begin
        bad_cnt++;
        $display("FAIL midmove_pre cyc=%0d got=%b want=%b", k, obs, expect_at(c, k));
      end
    end
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (obs !== 7'b0) begin
      bad_cnt++;
      $display("FAIL midmove_async got=%b want=%b", obs, 7'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    c = valid_cols[$urandom_range(0, 5)];
    start = 1'b1; colour = c;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= move_len(c) + DW + 2; k++) begin
      @(negedge clk);
      total_cnt++;
      if (obs !== expect_at(c, k)) begin
        bad_cnt++;
        $display("FAIL after_reset col=%b cyc=%0d got=%b want=%b", c, k, obs, expect_at(c, k));
      end
    end
  endtask

  // Each new start is raised in the idle cycle straight after DONE.
  task automatic test_back_to_back();
    logic [5:0] c;
    for (int n = 0; n < 3; n++) begin
      c = valid_cols[$urandom_range(0, 5)];
      start = 1'b1; colour = c;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= move_len(c) + DW + 2; k++) begin
        @(negedge clk);
        total_cnt++;
        if (obs !== expect_at(c, k)) begin
          bad_cnt++;
          $display("FAIL b2b n=%0d col=%b cyc=%0d got=%b want=%b", n, c, k, obs, expect_at(c, k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_red();
    test_invalid();
    test_random_moves();
    test_ignore_start();
    test_reset_midmove();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/platform_dispatch.md
# platform_dispatch

Outbound platform driver for the M&M sorter. On a start pulse it samples the one-hot colour code from the colour sensor and steps the 4-phase platform stepper from the feeder location to that colour's bin. It holds there for a drop dwell, then pulses `p3_on` so the return stage can rotate the platform back to the feeder. It sits between the colour sensor / motor sequencer and the return stage, and shares the `GPIO_1` coil bus with it through the top-level motor mux.

## Interface
- `PHASE_CYCLES`, default 97_656: clock cycles each coil phase is held (about 4 phases per 390_624 cycles at 50 MHz).
- `STEPS_PER_45`, default 32: coil phases per 45° of platform rotation.
- `DWELL_CYCLES`, default 25_000_000: cycles held at the bin for the drop (0.5 s).
- `clk`  in  1  50 MHz system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `colour`  in  6  one-hot colour code; sampled together with `start`.
- `GPIO_1`  out  4  stepper coil drive.
- `busy`  out  1  high from the cycle after an accepted start until DONE ends.
- `p3_on`  out  1  one-cycle pulse: bin reached and dwell complete.
- `err`  out  1  one-cycle pulse: start was given with an invalid colour.

## Operation
- Coil sequences:
  - CW: 1000, 0100, 0010, 0001, repeating.
  - CCW: 0001, 0010, 0100, 1000, repeating.
  - Every move starts at sequence index 0.
- Colour map (code → direction, 45° units):
  - red 000001 → CW, 2
  - brown 000010 → CW, 3
  - yellow 000100 → CW, 4
  - orange 001000 → CCW, 3
  - green 100000 → CCW, 2
  - blue 010000 → CCW, 1
- Total phases for a move = units × `STEPS_PER_45`. Phase counter and cycle counter are 32 bits and unsigned.
- States:
  - IDLE: `GPIO_1`=0. A start with a valid colour latches direction and phase total, then goes to MOVE. A start with an invalid colour (zero or not one-hot) pulses `err` and stays in IDLE.
  - MOVE: each phase is driven for exactly `PHASE_CYCLES` cycles. After the last phase completes, go to DWELL.
  - DWELL: lasts `DWELL_CYCLES` cycles, then go to DONE. With `DWELL_CYCLES`=0, DWELL is skipped.
  - DONE: `GPIO_1`=0 and `p3_on`=1 for one cycle, then go to IDLE.
- `start` is ignored outside IDLE, and `colour` changes after acceptance are ignored.
- Reset, including mid-move: all outputs go to 0, state to IDLE, counters to 0. No position memory is kept; the system controller re-homes.

## Timing
- Reset values: `GPIO_1`=0000, `busy`=0, `p3_on`=0, `err`=0.
- `start` accepted at edge N:
  - MOVE first phase drives `GPIO_1` from cycle N+1, with `busy`=1.
  - MOVE occupies P×`PHASE_CYCLES` cycles, where P is the phase total.
  - DWELL occupies `DWELL_CYCLES` cycles.
  - `p3_on` is high for the single DONE cycle; `busy` is still 1 in that cycle.
  - IDLE resumes the next cycle, with `busy`=0, and can accept a new start in that same cycle.
- `err` is asserted in cycle N+1 only, for a start rejected at edge N.
- All outputs are registered.

## Configuration
- `PLATFORM_HOLD_EN` defined: during DWELL, `GPIO_1` keeps the last MOVE phase energised (holding torque).
- Undefined: `GPIO_1`=0000 throughout DWELL.
- All other behaviour is identical in both builds.

## Structure
- Package `platform_pkg` holds:
  - colour code localparams (`COL_RED` … `COL_GREEN`);
  - the state enum;
  - the CW/CCW phase constants;
  - the colour→(direction, units) decode function.
- Sub-module `stepper_phase_gen` contains:
  - inputs: enable, direction, phase total;
  - outputs: coil pattern and a one-cycle `last` strobe;
  - the per-phase cycle counter and the sequence index.

## Test plan
All scenarios use `PHASE_CYCLES`=4, `STEPS_PER_45`=2, `DWELL_CYCLES`=3, HOLD undefined.
- Red: start at edge 0 with colour 000001 → cycles 1–16 show 1000×4, 0100×4, 0010×4, 0001×4; cycles 17–19 show 0000; `p3_on` high in cycle 20 only; `busy` high in cycles 1–20.
- Blue: colour 010000 → 0001×4, 0010×4 (8 cycles), then dwell, then `p3_on` at cycle 12.
- Invalid colour 000011 or 000000 → `err` high in cycle 1 only; `GPIO_1` stays 0; `busy` stays 0.
- Start re-asserted with 100000 during a red move → ignored; red timing unchanged.
- `rst_n` low at cycle 6 of a yellow move → all outputs 0 immediately; a new start after release begins at sequence index 0.
- `PLATFORM_HOLD_EN` defined, red move → cycles 17–19 hold 0001; everything else as in the red scenario.
